// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions.
// Holds the active-low segment patterns for hex digits 0..F, so the
// hex-to-segment encoders and the scan-capture decoder use one table.
// Segment vectors are [0:6] = a..g, so bit 0 is segment a.
package seg7_pkg;

  typedef logic [0:6] seg_t;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       hit;       // pattern is one of the 16 hex glyphs
    logic       is_blank;  // all segments off
    logic [3:0] nibble;    // decoded value, meaningful only when hit
  } seg_dec_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Multiplexed 7-segment scan bus.
//   seg_n : segments a..g, active low
//   an_n  : digit enables, active low, bit k = digit k
// master = display driver side, slave = capture side.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  seg_t                  seg_n;
  logic [NUM_DIGITS-1:0] an_n;

  modport master (output seg_n, output an_n);
  modport slave  (input  seg_n, input  an_n);

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational segment-pattern decoder.
//   seg : active-low segment pattern (a..g)
//   dec : {hit, is_blank, nibble}
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg_t     seg,
  output seg_dec_t dec
);

  always_comb begin
    dec          = '0;
    dec.is_blank = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        dec.hit    = 1'b1;
        dec.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment display.
// Samples {an_n, seg_n} every cycle, waits for STABLE_CYCLES identical
// samples, then commits the pattern once to the enabled digit.
//   clk, reset   : clock, synchronous active-high reset
//   scan         : seg7_scan_if.slave (seg_n, an_n)
//   hex_out      : decoded nibble per digit, digit k at [4k+3:4k]
//   digit_valid  : digit holds a decoded value
//   blank        : digit last committed as all-off
//   update       : one-cycle pulse on a valid/blank commit
//   err_pulse    : one-cycle pulse on invalid pattern or multi-digit enable
//   err_count    : saturating error count
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int ERRCNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_scan_if.slave              scan,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    update,
  output logic                    err_pulse,
  output logic [ERRCNT_W-1:0]     err_count
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int SAMP_W = NUM_DIGITS + 7;

  logic [SAMP_W-1:0]       samp_d, samp_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [4*NUM_DIGITS-1:0] hex_d, hex_q;
  logic [NUM_DIGITS-1:0]   valid_d, valid_q;
  logic [NUM_DIGITS-1:0]   blank_d, blank_q;
  logic                    update_d, update_q;
  logic                    err_d, err_q;
  logic [ERRCNT_W-1:0]     errcnt_d, errcnt_q;

  logic                    commit;
  seg_t                    samp_seg;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    an_any, an_multi;
  seg_dec_t                dec;

  assign samp_seg = samp_q[6:0];
  assign an_act   = ~samp_q[SAMP_W-1:7];
  assign an_any   = |an_act;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign an_multi = |(an_act & (an_act - 1'b1));

  seg7_to_hex u_dec (
    .seg (samp_seg),
    .dec (dec)
  );

  // Stability window: the counter reaches STABLE_CYCLES exactly once per
  // run of identical samples, so commit is a single-cycle event.
  always_comb begin
    samp_d = {scan.an_n, scan.seg_n};
    commit = 1'b0;
    if (samp_d != samp_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d  = cnt_q + 1'b1;
      commit = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    hex_d    = hex_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    errcnt_d = errcnt_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    if (commit && an_any) begin
      if (an_multi) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (an_act[k]) begin
            if (dec.hit) begin
              hex_d[4*k +: 4] = dec.nibble;
              valid_d[k]      = 1'b1;
              blank_d[k]      = 1'b0;
              update_d        = 1'b1;
            end else if (dec.is_blank) begin
              valid_d[k] = 1'b0;
              blank_d[k] = 1'b1;
              update_d   = 1'b1;
            end else begin
              valid_d[k] = 1'b0;
              blank_d[k] = 1'b0;
              err_d      = 1'b1;
            end
          end
        end
      end
      if (err_d && (errcnt_q != {ERRCNT_W{1'b1}})) begin
        errcnt_d = errcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q   <= '1;
      cnt_q    <= '0;
      hex_q    <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      update_q <= update_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign update      = update_q;
  assign err_pulse   = err_q;
  assign err_count   = errcnt_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: the stimulus side pushes the
// expected digit state whenever a commit is due, and a monitor pops and
// compares whenever the DUT pulses update or err_pulse.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int S  = 8;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) scan ();

  logic [4*ND-1:0] hex_out;
  logic [ND-1:0]   digit_valid, blank;
  logic            update, err_pulse;
  logic [EW-1:0]   err_count;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .ERRCNT_W(EW)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan        (scan),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .update      (update),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  // Independent copy of the glyph table, written from the display datasheet order.
  logic [0:6] ref_pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    bit          is_err;
    logic [31:0] state;  // {hex, valid, blank, err_count}
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: digit state plus the length of the current run of
  // identical samples (the value in the sample register after reset counts as 1).
  logic [4*ND-1:0] m_hex;
  logic [ND-1:0]   m_valid, m_blank;
  int              m_err;
  logic [ND+6:0]   m_prev;
  int              m_run;

  function automatic int ref_decode(input logic [0:6] s);
    if (s == 7'b1111111) return 16;
    for (int i = 0; i < 16; i++) if (ref_pat[i] == s) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_blank = '0; m_err = 0;
    m_prev = '1; m_run = 1;
  endtask

  task automatic model_commit(input logic [ND-1:0] an, input logic [0:6] seg);
    int zeros, k, d;
    exp_t e;
    zeros = 0; k = 0;
    for (int i = 0; i < ND; i++) if (!an[i]) begin zeros++; k = i; end
    if (zeros == 0) return;
    e.is_err = 1'b0;
    if (zeros > 1) begin
      e.is_err = 1'b1;
    end else begin
      d = ref_decode(seg);
      if (d >= 0 && d < 16) begin
        m_hex[4*k +: 4] = 4'(d); m_valid[k] = 1'b1; m_blank[k] = 1'b0;
      end else if (d == 16) begin
        m_valid[k] = 1'b0; m_blank[k] = 1'b1;
      end else begin
        m_valid[k] = 1'b0; m_blank[k] = 1'b0; e.is_err = 1'b1;
      end
    end
    if (e.is_err && m_err < 255) m_err++;
    e.state = {m_hex, m_valid, m_blank, 8'(m_err)};
    q.push_back(e);
  endtask

  // Drive one sample, let the DUT take it, and advance the model by one edge.
  task automatic step(input logic [ND-1:0] an, input logic [0:6] seg);
    logic [ND+6:0] cur;
    scan.an_n = an;
    scan.seg_n = seg;
    @(posedge clk);
    cur = {an, seg};
    if (reset) begin
      model_reset();
    end else begin
      if (cur == m_prev) m_run++;
      else begin m_prev = cur; m_run = 1; end
      if (m_run == S + 1) model_commit(an, seg);
    end
    #1;
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [0:6] seg, input int n);
    for (int i = 0; i < n; i++) step(an, seg);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    hold(4'b1111, 7'b1111111, n);
    reset = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the queue, and a queued
  // commit must produce its pulse in the cycle right after its edge.
  always @(negedge clk) begin
    exp_t e;
    if (update || err_pulse) begin
      chk("pulse_exclusive", {31'd0, update & err_pulse}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, update, err_pulse}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {30'd0, update, err_pulse}, {30'd0, !e.is_err, e.is_err});
        chk("commit_state", {hex_out, digit_valid, blank, err_count}, e.state);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("missing_pulse", 32'd0, {30'd0, !e.is_err, e.is_err});
    end
  end

  initial begin
    logic [ND-1:0] an;
    logic [0:6]    seg;
    scan.an_n = '1;
    scan.seg_n = '1;
    model_reset();

    // Reset state
    do_reset(3);
    chk("reset_state", {hex_out, digit_valid, blank, err_count, 6'd0, update, err_pulse}, 32'd0);

    // 1: digit 0 = 3, held long afterwards without a second commit
    hold(4'b1110, 7'b0000110, S + 1);
    chk("t1_hex0", {28'd0, hex_out[3:0]}, 32'd3);
    chk("t1_valid", {28'd0, digit_valid}, 32'b0001);
    hold(4'b1110, 7'b0000110, 20);

    // 2: glitching scan never stabilises, then b settles on digit 1
    for (int i = 0; i < 4; i++) begin
      hold(4'b1101, 7'b0001000, 3);
      hold(4'b1101, 7'b1100000, 3);
    end
    chk("t2_no_commit", {28'd0, digit_valid}, 32'b0001);
    hold(4'b1101, 7'b1100000, 12);
    chk("t2_hex1", {28'd0, hex_out[7:4]}, 32'hB);
    chk("t2_valid1", {31'd0, digit_valid[1]}, 32'd1);

    // 3: digit 2 = 5, then blanked
    hold(4'b1011, 7'b0100100, S + 1);
    hold(4'b1011, 7'b1111111, S + 1);
    chk("t3_blank2", {31'd0, blank[2]}, 32'd1);
    chk("t3_valid2", {31'd0, digit_valid[2]}, 32'd0);
    chk("t3_hex2", {28'd0, hex_out[11:8]}, 32'd5);

    // 4: invalid patterns until the error counter saturates
    hold(4'b1101, 7'b1010101, S + 1);
    chk("t4_errcnt1", {24'd0, err_count}, 32'd1);
    chk("t4_valid1", {31'd0, digit_valid[1]}, 32'd0);
    for (int i = 1; i < 300; i++)
      hold(4'b1101, (i % 2) ? 7'b1010100 : 7'b1010101, S + 1);
    chk("t4_errsat", {24'd0, err_count}, 32'd255);
    hold(4'b1100, 7'(($urandom)), S + 1);
    hold(4'b1111, 7'b0000000, S + 1);
    chk("t4_errsat_hold", {24'd0, err_count}, 32'd255);

    // 5: reset in the middle of a stable window
    hold(4'b1110, 7'b0000001, 5);
    reset = 1'b1;
    hold(4'b1110, 7'b0000001, 2);
    reset = 1'b0;
    chk("t5_reset_mid", {hex_out, digit_valid, blank, err_count, 6'd0, update, err_pulse}, 32'd0);
    hold(4'b1111, 7'b1111111, S + 2);

    // 6: loopback from the shared encoder table, scanning all digits
    do_reset(2);
    for (int v = 0; v < 16; v++)
      hold(~(4'b0001 << (v % 4)), SEG_HEX[v], S + 1);
    chk("t6_hex", {16'd0, hex_out}, 32'hFEDC);
    chk("t6_valid", {28'd0, digit_valid}, 32'hF);
    chk("t6_errcnt", {24'd0, err_count}, 32'd0);

    // Random scan traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: an = ~(4'b0001 << $urandom_range(0, 3));
        4:          an = 4'b1111;
        default:    an = 4'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    seg = ref_pat[$urandom_range(0, 15)];
        2:       seg = 7'b1111111;
        default: seg = 7'($urandom);
      endcase
      hold(an, seg, $urandom_range(1, 12));
    end
    hold(4'b1111, 7'b1111111, S + 3);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
